w_stage_datapath: RTL and testbench
===================================

# w_stage_datapath

- Writeback-stage datapath of the 3-stage RISC-V pipeline (FD → XM → W).
- Registers XM results into the W pipeline register and presents `inst_w` to the W control logic.
- Uses that logic's `wb_sel` / `reg_wen` / `csr_wen` / `reset_counters` decisions to:
  - extract and sign-extend load data;
  - form the register-file write-back value;
  - maintain the cycle and retired-instruction counters;
  - hold the `tohost` CSR.

## Interface

Parameters
- `W_SIZE`, 32, datapath/instruction width.
- `NOP`, 32'h0000_0013, instruction injected as a bubble.

Ports
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `flush`  in  1  squash the instruction entering W this edge (driven by BrTaken).
- `valid_xm`  in  1  XM holds a real instruction.
- `pc_xm`  in  32  XM program counter.
- `inst_xm`  in  32  XM instruction.
- `alu_xm`  in  32  XM ALU result (load address, CSR write data, arithmetic result).
- `dmem_dout`  in  32  synchronous DMEM read word, valid during W.
- `bios_dout`  in  32  synchronous BIOS read word, valid during W.
- `uart_rx_data`  in  8  UART receive byte.
- `uart_rx_valid`  in  1  UART receive data valid.
- `uart_tx_ready`  in  1  UART transmitter ready.
- `wb_sel`  in  3  0 PC+4, 1 ALU, 2 DMEM, 3 UART data, 4 UART status, 5 BIOS, 6 cycle count, 7 instruction count.
- `reg_wen`  in  1  W instruction writes rd.
- `csr_wen`  in  1  W instruction writes CSR 0x51E.
- `reset_counters`  in  1  clear both counters.
- `inst_w`  out  32  registered W instruction.
- `pc_w`  out  32  registered W PC.
- `valid_w`  out  1  W holds a real instruction.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  5  register-file write address (`inst_w[11:7]`).
- `rf_wdata`  out  32  write-back value.
- `cycle_cnt`  out  32  cycle counter.
- `inst_cnt`  out  32  retired-instruction counter.
- `tohost`  out  32  CSR 0x51E value.

## Operation

- Pipeline register: each edge loads `pc_xm`, `inst_xm`, `alu_xm` and `valid_xm & ~flush`. No stall input.
- Bubble on flush: `inst_w` loads `NOP`, `valid_w` loads 0, `pc_w` and ALU fields still load.
- `rf_we = reg_wen & valid_w & (rf_waddr != 0)`.
- Load extract applies to `wb_sel` 2 and 5 only. Source word is `dmem_dout` or `bios_dout`; `funct3 = inst_w[14:12]`; `off = alu_w[1:0]`.
  - LB/LBU: byte `off`, sign-extended / zero-extended.
  - LH/LHU: half selected by `off[1]`; `off[0]` is ignored.
  - LW: whole word; `off` ignored.
  - Other funct3 values: whole word.
- Other `wb_sel` values:
  - 0: `pc_w + 4`, 32-bit wrap (0xFFFF_FFFC → 0).
  - 1: `alu_w`.
  - 3: `{24'b0, uart_rx_data}`.
  - 4: `{30'b0, uart_rx_valid, uart_tx_ready}`.
  - 6 / 7: current counter values before this edge's update.
- Cycle counter: +1 every edge; wraps 0xFFFF_FFFF → 0.
- Instruction counter: +1 on each edge where `valid_w=1`; bubbles are not counted; wraps.
- `reset_counters` is qualified by `valid_w`. When asserted, both counters load 0 this edge, overriding any increment.

## Timing

- Reset (asynchronous assert, synchronous-safe deassert) sets:
  - `inst_w=NOP`, `valid_w=0`, `pc_w=0`, `alu_w=0`;
  - `cycle_cnt=0`, `inst_cnt=0`, `tohost=0`;
  - hence `rf_we=0` and `rf_wdata=4`.
- Reset mid-instruction discards W contents immediately, without waiting for a clock edge.
- Latency: XM → W is one edge. `rf_wdata` / `rf_we` are combinational from W state and memory outputs in the same cycle; the register file captures them on the next edge.
- `flush` with `valid_xm=0`: still a bubble; no difference.
- `reset_counters` and the counter-increment condition together: clear wins.
- The counter value read through `wb_sel` 6/7 is the pre-edge value. An instruction reading `inst_cnt` sees the count excluding itself.
- First cycle after reset deassertion: `cycle_cnt` reads 0, then 1 on the following cycle.

## Configuration

- `W_TOHOST_CSR_EN` defined:
  - 32-bit `tohost` register; loads `alu_w` on an edge where `csr_wen & valid_w`.
  - A write coinciding with reset is lost.
- `W_TOHOST_CSR_EN` undefined:
  - No register is built; `tohost` is tied to 0.
  - `csr_wen` is ignored.
  - All other behaviour is unchanged.

## Test plan

- Reset: drive `rst=0` mid-run with `valid_xm=1` → immediately `inst_w=32'h13`, `valid_w=0`, `rf_we=0`, counters=0, `tohost=0`.
- Load extract, `dmem_dout=32'h8081_F2A3`, `wb_sel=2`:
  - LB at `off=3` → `FFFF_FF80`;
  - LBU at `off=0` → `0000_00A3`;
  - LH at `off=2` → `FFFF_8081`;
  - LHU at `off=1` → `0000_F2A3`;
  - LW → `8081_F2A3`.
- Flush: `valid_xm=1`, `flush=1`, `inst_xm=ADDI x5` → next cycle `valid_w=0`, `inst_w=NOP`, `rf_we=0`, `inst_cnt` unchanged.
- Counters:
  - 10 valid instructions then 3 bubbles → `inst_cnt=10`, `cycle_cnt=13`;
  - then `reset_counters` with a valid instruction and an increment due → both read 0 next cycle.
- Write-back sources and x0 guard:
  - `wb_sel=0` with `pc_w=32'hFFFF_FFFC` → `rf_wdata=0`;
  - `wb_sel=4` with rx valid=1, tx ready=0 → `2`;
  - `reg_wen=1` with rd=x0 → `rf_we=0`.
- CSR (`W_TOHOST_CSR_EN` defined): csrw with `alu_w=32'h1` → `tohost=1` next cycle. Without the macro, the same stimulus leaves `tohost=0`.

Source files
------------

// File: rtl/w_stage_datapath.sv
// -----------------------------------------------------------------------------
// w_stage_datapath
//
// Writeback-stage datapath of the 3-stage RISC-V pipeline (FD -> XM -> W).
// XM results are registered into the W pipeline register. inst_w is exported to
// the W control logic, and that logic's decisions (wb_sel, reg_wen, csr_wen,
// reset_counters) are used here to form the register-file write-back value,
// run the cycle / retired-instruction counters and hold the tohost CSR.
//
// Optional feature macro: W_TOHOST_CSR_EN
//   defined   : 32-bit tohost register, written with alu_w on csr_wen & valid_w.
//   undefined : no register; tohost tied to 0 and csr_wen ignored.
//
// Ports
//   clk, rst         clock (rising edge) and asynchronous active-low reset
//   flush            squash the instruction entering W this edge
//   valid_xm         XM holds a real instruction
//   pc_xm, inst_xm   XM program counter / instruction
//   alu_xm           XM ALU result (load address, CSR data, arithmetic result)
//   dmem_dout        synchronous DMEM read word, valid during W
//   bios_dout        synchronous BIOS read word, valid during W
//   uart_rx_data     UART receive byte
//   uart_rx_valid    UART receive data valid
//   uart_tx_ready    UART transmitter ready
//   wb_sel           write-back source select (see wb_sel_e)
//   reg_wen          W instruction writes rd
//   csr_wen          W instruction writes CSR 0x51E
//   reset_counters   clear both counters (qualified by valid_w)
//   inst_w, pc_w     registered W instruction / PC
//   valid_w          W holds a real instruction
//   rf_we            register-file write enable
//   rf_waddr         register-file write address (inst_w[11:7])
//   rf_wdata         register-file write-back value
//   cycle_cnt        cycle counter
//   inst_cnt         retired-instruction counter
//   tohost           CSR 0x51E value
// -----------------------------------------------------------------------------
module w_stage_datapath #(
    parameter int unsigned            W_SIZE = 32,
    parameter logic [W_SIZE-1:0]      NOP    = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_xm,
    input  logic [W_SIZE-1:0] pc_xm,
    input  logic [W_SIZE-1:0] inst_xm,
    input  logic [W_SIZE-1:0] alu_xm,
    input  logic [W_SIZE-1:0] dmem_dout,
    input  logic [W_SIZE-1:0] bios_dout,
    input  logic [7:0]        uart_rx_data,
    input  logic              uart_rx_valid,
    input  logic              uart_tx_ready,
    input  logic [2:0]        wb_sel,
    input  logic              reg_wen,
    input  logic              csr_wen,
    input  logic              reset_counters,
    output logic [W_SIZE-1:0] inst_w,
    output logic [W_SIZE-1:0] pc_w,
    output logic              valid_w,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [W_SIZE-1:0] rf_wdata,
    output logic [W_SIZE-1:0] cycle_cnt,
    output logic [W_SIZE-1:0] inst_cnt,
    output logic [W_SIZE-1:0] tohost
);

    typedef enum logic [2:0] {
        WbPc4      = 3'd0,
        WbAlu      = 3'd1,
        WbDmem     = 3'd2,
        WbUartData = 3'd3,
        WbUartStat = 3'd4,
        WbBios     = 3'd5,
        WbCycle    = 3'd6,
        WbInst     = 3'd7
    } wb_sel_e;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // ------------------------------------------------------------------------
    // W pipeline register
    // ------------------------------------------------------------------------
    logic [W_SIZE-1:0] inst_w_q, inst_w_d;
    logic [W_SIZE-1:0] pc_w_q,   pc_w_d;
    logic [W_SIZE-1:0] alu_w_q,  alu_w_d;
    logic              valid_w_q, valid_w_d;

    always_comb begin
        pc_w_d    = pc_xm;
        alu_w_d   = alu_xm;
        // A flushed slot becomes a NOP bubble; PC and ALU fields load regardless.
        inst_w_d  = flush ? NOP : inst_xm;
        valid_w_d = valid_xm & ~flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_w_q  <= NOP;
            pc_w_q    <= '0;
            alu_w_q   <= '0;
            valid_w_q <= 1'b0;
        end else begin
            inst_w_q  <= inst_w_d;
            pc_w_q    <= pc_w_d;
            alu_w_q   <= alu_w_d;
            valid_w_q <= valid_w_d;
        end
    end

    assign inst_w  = inst_w_q;
    assign pc_w    = pc_w_q;
    assign valid_w = valid_w_q;

    // ------------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------------
    logic [W_SIZE-1:0] cycle_q, cycle_d;
    logic [W_SIZE-1:0] icnt_q,  icnt_d;
    logic              cnt_clr;

    assign cnt_clr = reset_counters & valid_w_q;

    always_comb begin
        cycle_d = cycle_q + {{(W_SIZE-1){1'b0}}, 1'b1};
        icnt_d  = icnt_q;
        if (valid_w_q) begin
            icnt_d = icnt_q + {{(W_SIZE-1){1'b0}}, 1'b1};
        end
        // Clear overrides any increment due on the same edge.
        if (cnt_clr) begin
            cycle_d = '0;
            icnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q <= '0;
            icnt_q  <= '0;
        end else begin
            cycle_q <= cycle_d;
            icnt_q  <= icnt_d;
        end
    end

    assign cycle_cnt = cycle_q;
    assign inst_cnt  = icnt_q;

    // ------------------------------------------------------------------------
    // tohost CSR
    // ------------------------------------------------------------------------
`ifdef W_TOHOST_CSR_EN
    logic [W_SIZE-1:0] tohost_q, tohost_d;

    always_comb begin
        tohost_d = tohost_q;
        if (csr_wen && valid_w_q) begin
            tohost_d = alu_w_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tohost_q <= '0;
        end else begin
            tohost_q <= tohost_d;
        end
    end

    assign tohost = tohost_q;
`else
    logic unused_csr_wen;

    assign unused_csr_wen = csr_wen;
    assign tohost         = '0;
`endif

    // ------------------------------------------------------------------------
    // Load extraction
    // ------------------------------------------------------------------------
    logic [2:0]        funct3;
    logic [1:0]        load_off;
    logic [W_SIZE-1:0] load_word;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic [W_SIZE-1:0] load_data;

    assign funct3   = inst_w_q[14:12];
    assign load_off = alu_w_q[1:0];

    always_comb begin
        load_word = (wb_sel_e'(wb_sel) == WbBios) ? bios_dout : dmem_dout;

        unique case (load_off)
            2'd0: load_byte = load_word[7:0];
            2'd1: load_byte = load_word[15:8];
            2'd2: load_byte = load_word[23:16];
            2'd3: load_byte = load_word[31:24];
        endcase

        // Halfword select ignores off[0]; misaligned halves are not split.
        load_half = load_off[1] ? load_word[31:16] : load_word[15:0];

        case (funct3)
            F3_LB:   load_data = {{(W_SIZE-8){load_byte[7]}}, load_byte};
            F3_LBU:  load_data = {{(W_SIZE-8){1'b0}}, load_byte};
            F3_LH:   load_data = {{(W_SIZE-16){load_half[15]}}, load_half};
            F3_LHU:  load_data = {{(W_SIZE-16){1'b0}}, load_half};
            F3_LW:   load_data = load_word;
            default: load_data = load_word;
        endcase
    end

    // ------------------------------------------------------------------------
    // Write-back mux
    // ------------------------------------------------------------------------
    always_comb begin
        unique case (wb_sel_e'(wb_sel))
            WbPc4:      rf_wdata = pc_w_q + {{(W_SIZE-3){1'b0}}, 3'd4};
            WbAlu:      rf_wdata = alu_w_q;
            WbDmem:     rf_wdata = load_data;
            WbUartData: rf_wdata = {{(W_SIZE-8){1'b0}}, uart_rx_data};
            WbUartStat: rf_wdata = {{(W_SIZE-2){1'b0}}, uart_rx_valid, uart_tx_ready};
            WbBios:     rf_wdata = load_data;
            // Counters are read pre-update: an instruction never counts itself.
            WbCycle:    rf_wdata = cycle_q;
            WbInst:     rf_wdata = icnt_q;
        endcase
    end

    assign rf_waddr = inst_w_q[11:7];
    assign rf_we    = reg_wen & valid_w_q & (rf_waddr != 5'd0);

endmodule

// File: tb/tb_w_stage_datapath.sv
module tb_w_stage_datapath;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        valid_xm;
    logic [31:0] pc_xm;
    logic [31:0] inst_xm;
    logic [31:0] alu_xm;
    logic [31:0] dmem_dout;
    logic [31:0] bios_dout;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_tx_ready;
    logic [2:0]  wb_sel;
    logic        reg_wen;
    logic        csr_wen;
    logic        reset_counters;
    logic [31:0] inst_w;
    logic [31:0] pc_w;
    logic        valid_w;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] cycle_cnt;
    logic [31:0] inst_cnt;
    logic [31:0] tohost;

    int n_checks;
    int n_fail;

    w_stage_datapath dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .valid_xm       (valid_xm),
        .pc_xm          (pc_xm),
        .inst_xm        (inst_xm),
        .alu_xm         (alu_xm),
        .dmem_dout      (dmem_dout),
        .bios_dout      (bios_dout),
        .uart_rx_data   (uart_rx_data),
        .uart_rx_valid  (uart_rx_valid),
        .uart_tx_ready  (uart_tx_ready),
        .wb_sel         (wb_sel),
        .reg_wen        (reg_wen),
        .csr_wen        (csr_wen),
        .reset_counters (reset_counters),
        .inst_w         (inst_w),
        .pc_w           (pc_w),
        .valid_w        (valid_w),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .cycle_cnt      (cycle_cnt),
        .inst_cnt       (inst_cnt),
        .tohost         (tohost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present an XM instruction and let one edge move it into W.
    task automatic load_w(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] alu,
                          input logic v, input logic f);
        pc_xm    = pc;
        inst_xm  = inst;
        alu_xm   = alu;
        valid_xm = v;
        flush    = f;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADDI_X5 = 32'h0000_0293;
    localparam logic [31:0] LOAD_X5 = 32'h0000_0283;
    localparam logic [31:0] CSRW    = 32'h51E2_9073;

    logic [2:0]  f3_tab  [0:9] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd0, 3'd4, 3'd1, 3'd2, 3'd6};
    logic [31:0] off_tab [0:9] = '{32'd3, 32'd0, 32'd2, 32'd1, 32'd0,
                                   32'd1, 32'd2, 32'd0, 32'd3, 32'd1};
    logic [31:0] exp_tab [0:9] = '{32'hFFFF_FF80, 32'h0000_00A3, 32'hFFFF_8081, 32'h0000_F2A3,
                                   32'h8081_F2A3, 32'hFFFF_FFF2, 32'h0000_0081, 32'hFFFF_F2A3,
                                   32'h8081_F2A3, 32'h8081_F2A3};

    logic [31:0] exp_tohost;

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b0;
        flush          = 1'b0;
        valid_xm       = 1'b0;
        pc_xm          = '0;
        inst_xm        = '0;
        alu_xm         = '0;
        dmem_dout      = '0;
        bios_dout      = '0;
        uart_rx_data   = '0;
        uart_rx_valid  = 1'b0;
        uart_tx_ready  = 1'b0;
        wb_sel         = 3'd0;
        reg_wen        = 1'b1;
        csr_wen        = 1'b0;
        reset_counters = 1'b0;
`ifdef W_TOHOST_CSR_EN
        exp_tohost = 32'h1;
`else
        exp_tohost = 32'h0;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_inst_w", inst_w, 32'h13);
        check("rst_valid_w", {31'b0, valid_w}, 32'h0);
        check("rst_pc_w", pc_w, 32'h0);
        check("rst_rf_we", {31'b0, rf_we}, 32'h0);
        check("rst_rf_wdata", rf_wdata, 32'h4);
        rst = 1'b1;
        #1;
        check("cycle_after_deassert", cycle_cnt, 32'h0);

        // Counters: 10 valid then 3 bubbles
        for (int i = 0; i < 10; i++) begin
            load_w(32'h100 + 32'(4 * i), ADDI_X5, 32'(i), 1'b1, 1'b0);
            if (i == 0) begin
                check("cycle_first_edge", cycle_cnt, 32'h1);
                check("icnt_first_edge", inst_cnt, 32'h0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            load_w(32'h200, ADDI_X5, 32'h0, 1'b0, 1'b0);
        end
        check("cycle_13", cycle_cnt, 32'd13);
        check("icnt_10", inst_cnt, 32'd10);
        wb_sel = 3'd6;
        #1;
        check("wb_cycle", rf_wdata, 32'd13);
        wb_sel = 3'd7;
        #1;
        check("wb_icnt", rf_wdata, 32'd10);
        wb_sel = 3'd0;

        // reset_counters is ignored while W holds a bubble, then wins over increment
        reset_counters = 1'b1;
        load_w(32'h300, ADDI_X5, 32'h0, 1'b1, 1'b0);
        check("clr_bubble_cycle", cycle_cnt, 32'd14);
        check("clr_bubble_icnt", inst_cnt, 32'd10);
        load_w(32'h304, ADDI_X5, 32'h0, 1'b1, 1'b0);
        check("clr_cycle", cycle_cnt, 32'd0);
        check("clr_icnt", inst_cnt, 32'd0);
        reset_counters = 1'b0;

        // Load extraction from DMEM
        dmem_dout = 32'h8081_F2A3;
        bios_dout = 32'h1122_33F4;
        wb_sel    = 3'd2;
        for (int i = 0; i < 10; i++) begin
            load_w(32'h400, LOAD_X5 | {17'b0, f3_tab[i], 12'b0}, 32'h1000_0000 | off_tab[i],
                   1'b1, 1'b0);
            check($sformatf("load_dmem_%0d", i), rf_wdata, exp_tab[i]);
        end

        // Load extraction from BIOS
        wb_sel = 3'd5;
        load_w(32'h404, LOAD_X5 | 32'h0000_4000, 32'h1, 1'b1, 1'b0);
        check("bios_lbu", rf_wdata, 32'h0000_0033);
        load_w(32'h408, LOAD_X5, 32'h0, 1'b1, 1'b0);
        check("bios_lb", rf_wdata, 32'hFFFF_FFF4);

        // Write-back sources and x0 guard
        load_w(32'hFFFF_FFFC, ADDI_X5, 32'h1234_5678, 1'b1, 1'b0);
        wb_sel = 3'd0;
        #1;
        check("wb_pc4_wrap", rf_wdata, 32'h0);
        check("rf_we_x5", {31'b0, rf_we}, 32'h1);
        check("rf_waddr", {27'b0, rf_waddr}, 32'd5);
        check("pc_w", pc_w, 32'hFFFF_FFFC);
        wb_sel = 3'd1;
        #1;
        check("wb_alu", rf_wdata, 32'h1234_5678);
        wb_sel       = 3'd3;
        uart_rx_data = 8'hA5;
        #1;
        check("wb_uart_data", rf_wdata, 32'h0000_00A5);
        wb_sel        = 3'd4;
        uart_rx_valid = 1'b1;
        uart_tx_ready = 1'b0;
        #1;
        check("wb_uart_stat_rx", rf_wdata, 32'h2);
        uart_rx_valid = 1'b0;
        uart_tx_ready = 1'b1;
        #1;
        check("wb_uart_stat_tx", rf_wdata, 32'h1);
        reg_wen = 1'b0;
        #1;
        check("rf_we_no_wen", {31'b0, rf_we}, 32'h0);
        reg_wen = 1'b1;
        load_w(32'h500, 32'h0000_0013, 32'h0, 1'b1, 1'b0);
        check("rf_we_x0", {31'b0, rf_we}, 32'h0);
        wb_sel = 3'd0;

        // Flush
        rst = 1'b0;
        #1;
        rst = 1'b1;
        load_w(32'h600, ADDI_X5, 32'h0, 1'b1, 1'b0);
        check("noflush_valid", {31'b0, valid_w}, 32'h1);
        check("noflush_inst", inst_w, ADDI_X5);
        load_w(32'h604, ADDI_X5, 32'h0, 1'b1, 1'b1);
        check("flush_valid", {31'b0, valid_w}, 32'h0);
        check("flush_inst", inst_w, 32'h13);
        check("flush_pc", pc_w, 32'h604);
        check("flush_rf_we", {31'b0, rf_we}, 32'h0);
        check("flush_icnt_a", inst_cnt, 32'h1);
        load_w(32'h608, ADDI_X5, 32'h0, 1'b0, 1'b1);
        check("flush_icnt_b", inst_cnt, 32'h1);
        check("flush_inv_valid", {31'b0, valid_w}, 32'h0);

        // tohost CSR
        load_w(32'h700, CSRW, 32'h1, 1'b1, 1'b0);
        csr_wen = 1'b1;
        #1;
        check("tohost_pre", tohost, 32'h0);
        load_w(32'h704, CSRW, 32'h7, 1'b1, 1'b1);
        check("tohost_write", tohost, exp_tohost);
        load_w(32'h708, ADDI_X5, 32'h9, 1'b0, 1'b0);
        check("tohost_bubble_hold", tohost, exp_tohost);
        csr_wen = 1'b0;

        // Asynchronous reset mid-instruction
        load_w(32'h800, ADDI_X5, 32'h5, 1'b1, 1'b0);
        wb_sel = 3'd0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_inst_w", inst_w, 32'h13);
        check("arst_valid_w", {31'b0, valid_w}, 32'h0);
        check("arst_rf_we", {31'b0, rf_we}, 32'h0);
        check("arst_rf_wdata", rf_wdata, 32'h4);
        check("arst_pc_w", pc_w, 32'h0);
        check("arst_cycle", cycle_cnt, 32'h0);
        check("arst_icnt", inst_cnt, 32'h0);
        check("arst_tohost", tohost, 32'h0);
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
